crc_code_checker: RTL and testbench

- Receive-side counterpart of the serial CRC encoder.
- Captures a DATA_WIDTH+CRC_WIDTH codeword, shifts it MSB-first through an internal serial polynomial divider, and reports the remainder (syndrome), an error flag and the extracted data word.
- Contains its own IDLE/SHIFT/DONE controller and datapath; sits between memory read-out and the consumer of protected data.

---
 rtl/crc_code_checker.sv | 153 +++++++++++++++
 tb/tb_crc_code_checker.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/crc_code_checker.sv
// crc_code_checker
// Receive-side CRC checker. A {data, crc} codeword is captured on start,
// shifted MSB-first through a serial polynomial divider, and the final
// remainder (syndrome), an error flag and the extracted data word are
// published when the last bit has been absorbed.
//
// Handshake: start is a request qualified only by the IDLE state; there is
// no ready output, so a start seen in SHIFT or DONE is simply dropped.
// data_valid is a one-cycle strobe that marks the cycle in which fresh
// results are first visible; results then hold until the next check ends.
module crc_code_checker #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    CRC_WIDTH  = 4,
    parameter logic [CRC_WIDTH-1:0]  POLY       = 4'b0011
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [DATA_WIDTH+CRC_WIDTH-1:0] codeword_in,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic [CRC_WIDTH-1:0]            syndrome,
    output logic                            error_detected,
    output logic                            data_valid,
    output logic                            checker_busy
);

    localparam int CW    = DATA_WIDTH + CRC_WIDTH;
    localparam int CNT_W = $clog2(CW);

    // Counter value seen at the edge that absorbs the final codeword bit.
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;

    logic [CNT_W-1:0]      counter;
    logic [CW-1:0]         shift_reg;
    logic [CRC_WIDTH-1:0]  rem;
    logic [CRC_WIDTH-1:0]  rem_next;
    logic [DATA_WIDTH-1:0] capture;

    logic                  bit_in;
    logic                  accept;
    logic                  last_shift;

    // Control qualifiers shared by the FSM and the datapath.
    always_comb begin
        accept     = 1'b0;
        last_shift = 1'b0;
        if (state == IDLE && start) begin
            accept = 1'b1;
        end
        if (state == SHIFT && counter == LAST_COUNT) begin
            last_shift = 1'b1;
        end
    end

    // One step of the serial divider: multiply remainder by x, add the
    // incoming bit, and reduce by G whenever the x^CRC_WIDTH term appears.
    always_comb begin
        bit_in   = shift_reg[CW-1];
        rem_next = {rem[CRC_WIDTH-2:0], bit_in};
        if (rem[CRC_WIDTH-1]) begin
            rem_next = rem_next ^ POLY;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: IDLE waits for start, SHIFT runs CW edges, DONE lasts one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (last_shift) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Status outputs decoded purely from the current state.
    always_comb begin
        checker_busy = 1'b0;
        data_valid   = 1'b0;
        case (state)
            SHIFT:   checker_busy = 1'b1;
            DONE:    data_valid   = 1'b1;
            default: begin
                checker_busy = 1'b0;
                data_valid   = 1'b0;
            end
        endcase
    end

    // Working datapath: capture on accept, then shift and divide once per SHIFT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            rem       <= '0;
            counter   <= '0;
            capture   <= '0;
        end else if (accept) begin
            shift_reg <= codeword_in;
            rem       <= '0;
            counter   <= '0;
            capture   <= codeword_in[CW-1:CRC_WIDTH];
        end else if (state == SHIFT) begin
            shift_reg <= {shift_reg[CW-2:0], 1'b0};
            rem       <= rem_next;
            counter   <= counter + 1'b1;
        end
    end

    // Result registers: loaded on the edge that leaves SHIFT, held otherwise.
    // The syndrome takes the divider value that includes the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syndrome       <= '0;
            error_detected <= 1'b0;
            data_out       <= '0;
        end else if (last_shift) begin
            syndrome       <= rem_next;
            error_detected <= |rem_next;
            data_out       <= capture;
        end
    end

endmodule

// File: tb/tb_crc_code_checker.sv
// Directed bench for crc_code_checker (DATA_WIDTH=8, CRC_WIDTH=4, G=x^4+x+1).
module tb_crc_code_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] codeword_in;
    logic [7:0]  data_out;
    logic [3:0]  syndrome;
    logic        error_detected;
    logic        data_valid;
    logic        checker_busy;

    int n_checks;
    int n_errors;

    // expected results for the back-to-back run
    logic [3:0] exp_q[$];
    logic [7:0] exp_d_q[$];

    crc_code_checker #(
        .DATA_WIDTH (8),
        .CRC_WIDTH  (4),
        .POLY       (4'b0011)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .codeword_in    (codeword_in),
        .data_out       (data_out),
        .syndrome       (syndrome),
        .error_detected (error_detected),
        .data_valid     (data_valid),
        .checker_busy   (checker_busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_data"},  32'(data_out),       32'h0);
        check_val({tag, "_syn"},   32'(syndrome),       32'h0);
        check_val({tag, "_err"},   32'(error_detected), 32'h0);
        check_val({tag, "_valid"}, 32'(data_valid),     32'h0);
        check_val({tag, "_busy"},  32'(checker_busy),   32'h0);
    endtask

    // Issue one start pulse and check the full result of that check.
    task automatic run_check(input string tag, input logic [11:0] cw,
                             input logic [7:0] exp_data, input logic [3:0] exp_syn);
        int busy_cnt;
        int cycles;
        @(negedge clk);
        codeword_in = cw;
        start       = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        busy_cnt = 0;
        cycles   = 0;
        while (!data_valid && cycles < 40) begin
            if (checker_busy) busy_cnt++;
            cycles++;
            @(negedge clk);
        end
        check_val({tag, "_valid_seen"}, 32'(data_valid), 32'h1);
        check_val({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd12);
        check_val({tag, "_data"}, 32'(data_out), 32'(exp_data));
        check_val({tag, "_syn"}, 32'(syndrome), 32'(exp_syn));
        check_val({tag, "_err"}, 32'(error_detected), 32'(exp_syn != 4'h0));
        @(negedge clk);
        check_val({tag, "_valid_pulse"}, 32'(data_valid), 32'h0);
    endtask

    initial begin
        int dv_cnt;
        int cycle;
        int npulse;
        int last_pulse;
        logic [3:0] hold_syn;

        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        codeword_in = 12'h000;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // good codeword, then single-bit errors
        run_check("good_a5b", 12'hA5B, 8'hA5, 4'h0);
        run_check("flip_b0", 12'hA5A, 8'hA5, 4'h1);
        run_check("flip_b4", 12'hA4B, 8'hA4, 4'h3);

        // start pulses during SHIFT and DONE are ignored; input change after accept too
        @(negedge clk);
        codeword_in = 12'hA5A;
        start       = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        dv_cnt = 0;
        for (int k = 1; k <= 25; k++) begin
            if (data_valid) dv_cnt++;
            if (k == 13) check_val("ign_dv_at_13", 32'(data_valid), 32'h1);
            start = (k == 3 || k == 12 || k == 13);
            if (k == 3) codeword_in = 12'hA4B;
            @(negedge clk);
        end
        start = 1'b0;
        check_val("ign_dv_count", 32'(dv_cnt), 32'd1);
        check_val("ign_busy_after", 32'(checker_busy), 32'h0);
        check_val("ign_syn", 32'(syndrome), 32'h1);
        check_val("ign_data", 32'(data_out), 32'hA5);
        run_check("after_ign", 12'hA4B, 8'hA4, 4'h3);

        // reset in the middle of SHIFT
        @(negedge clk);
        codeword_in = 12'hA5A;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check_val("rst_busy_before", 32'(checker_busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst_n  = 1'b1;
        dv_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (data_valid || checker_busy) dv_cnt++;
        end
        check_val("rst_no_activity", 32'(dv_cnt), 32'd0);
        run_check("zero_cw", 12'h000, 8'h00, 4'h0);

        // start held high for three back-to-back checks
        exp_q   = {4'h0, 4'h3, 4'h3};
        exp_d_q = {8'hA5, 8'hA4, 8'hA4};
        @(negedge clk);
        codeword_in = 12'hA5B;
        start       = 1'b1;
        cycle       = 0;
        npulse      = 0;
        last_pulse  = 0;
        hold_syn    = 4'h0;
        while (npulse < 3 && cycle < 100) begin
            @(negedge clk);
            cycle++;
            if (data_valid) begin
                logic [3:0] es;
                logic [7:0] ed;
                es = exp_q.pop_front();
                ed = exp_d_q.pop_front();
                check_val("b2b_syn", 32'(syndrome), 32'(es));
                check_val("b2b_err", 32'(error_detected), 32'(es != 4'h0));
                check_val("b2b_data", 32'(data_out), 32'(ed));
                if (npulse == 0) begin
                    check_val("b2b_first_at", 32'(cycle), 32'd13);
                    codeword_in = 12'hA4B;
                end else begin
                    check_val("b2b_spacing", 32'(cycle - last_pulse), 32'd14);
                end
                hold_syn   = es;
                last_pulse = cycle;
                npulse++;
                if (npulse == 3) start = 1'b0;
            end else if (npulse > 0 && cycle - last_pulse == 7) begin
                check_val("b2b_hold_syn", 32'(syndrome), 32'(hold_syn));
                check_val("b2b_hold_busy", 32'(checker_busy), 32'h1);
            end
        end
        check_val("b2b_pulses", 32'(npulse), 32'd3);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_val("b2b_idle_busy", 32'(checker_busy), 32'h0);
        check_val("b2b_final_syn", 32'(syndrome), 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
